// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and dispatch with single-cycle flush.
// Optional same-cycle empty-queue bypass when IQ_BYPASS_EN is defined.
module instr_queue #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push_valid,
    input  logic [DATA_WIDTH-1:0]       push_data,
    output logic                        push_ready,
    output logic                        instr_valid,
    output logic [DATA_WIDTH-1:0]       instr_data,
    input  logic                        instr_pop,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  empty, full;
    logic                  push_fire, pop_fire;

    // Wrap bit distinguishes full from empty when the index bits match.
    always_comb begin
        empty = (rptr_q == wptr_q);
        full  = (rptr_q[IDX_W-1:0] == wptr_q[IDX_W-1:0]) && (rptr_q[IDX_W] != wptr_q[IDX_W]);
    end

`ifdef IQ_BYPASS_EN
    logic bypass;

    // An empty queue forwards the fetch packet; if dispatch takes it, it is never stored.
    always_comb begin
        bypass      = empty && push_valid && !flush;
        push_ready  = !full;
        instr_valid = !empty || bypass;
        instr_data  = empty ? push_data : mem_q[rptr_q[IDX_W-1:0]];
        push_fire   = push_valid && !full && !flush && !(bypass && instr_pop);
        pop_fire    = instr_pop && !empty && !flush;
    end
`else
    always_comb begin
        push_ready  = !full;
        instr_valid = !empty;
        instr_data  = mem_q[rptr_q[IDX_W-1:0]];
        push_fire   = push_valid && !full && !flush;
        pop_fire    = instr_pop && !empty && !flush;
    end
`endif

    always_comb begin
        rptr_d  = rptr_q + PTR_W'(pop_fire);
        wptr_d  = wptr_q + PTR_W'(push_fire);
        count_d = count_q + PTR_W'(push_fire) - PTR_W'(pop_fire);
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset or cleared on flush; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wptr_q[IDX_W-1:0]] <= push_data;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model plus directed literal checks.
module tb_instr_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic          instr_pop;
    logic [4:0]    count;

    int total = 0;
    int bad   = 0;

    instr_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_pop  (instr_pop),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pkt(input logic [31:0] pc);
        return {pc, pc ^ 32'h5A5A_0000};
    endfunction

    // Reference model: a plain queue of packets, checked and updated between edges.
    logic [63:0] mq[$];
    logic        ev, byp, pf, wf;
    int          sz;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            ev  = (sz > 0);
            byp = 1'b0;
`ifdef IQ_BYPASS_EN
            if (sz == 0 && push_valid && !flush) begin
                ev  = 1'b1;
                byp = 1'b1;
            end
`endif
            chk("m_valid", 64'(instr_valid), 64'(ev));
            chk("m_ready", 64'(push_ready), 64'(sz < DEPTH));
            chk("m_count", 64'(count), 64'(sz));
            if (ev) chk("m_data", instr_data, byp ? push_data : mq[0]);
            if (instr_pop) chk("pop_protocol", 64'(instr_valid), 64'd1);
            if (flush) begin
                mq.delete();
            end else if (!(byp && instr_pop)) begin
                pf = instr_pop && (sz > 0);
                wf = push_valid && (sz < DEPTH);
                if (pf) void'(mq.pop_front());
                if (wf) mq.push_back(push_data);
            end
        end
    end

    task automatic drv(input logic pv, input logic [63:0] pd, input logic pop, input logic fl);
        push_valid = pv;
        push_data  = pd;
        instr_pop  = pop;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_ready", 64'(push_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        tick();

        // Async reset with entries present.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, pkt(32'h100 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("pre_rst_count", 64'(count), 64'd3);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(instr_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to full, reject one extra, drain in order.
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, pkt(32'h1000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(push_ready), 64'd0);
        drv(1'b1, pkt(32'h1040), 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("no_17th_count", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            drv(1'b0, 64'd0, 1'b1, 1'b0);
            #1 chk("drain_pc", 64'(instr_data[63:32]), 64'h1000 + 64'(4 * i));
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("drained_valid", 64'(instr_valid), 64'd0);

        // Index wrap: 10 pushes, 8 pops, 12 pushes.
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, pkt(32'h2000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 64'd0, 1'b1, 1'b0);
            #1 chk("wrap_pop_pc", 64'(instr_data[63:32]), 64'h2000 + 64'(4 * i));
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drv(1'b1, pkt(32'h3000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("wrap_count", 64'(count), 64'd14);
        for (int i = 0; i < 14; i++) begin
            drv(1'b0, 64'd0, 1'b1, 1'b0);
            #1 chk("wrap_drain_pc", 64'(instr_data[63:32]),
                   (i < 2) ? 64'h2020 + 64'(4 * i) : 64'h3000 + 64'(4 * (i - 2)));
            tick();
        end

        // Streaming push+pop at count 5.
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, pkt(32'h4000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 50; i++) begin
            drv(1'b1, pkt(32'h4014 + 32'(4 * i)), 1'b1, 1'b0);
            #1 chk("stream_pc", 64'(instr_data[63:32]), 64'h4000 + 64'(4 * i));
            chk("stream_count", 64'(count), 64'd5);
            tick();
        end
        for (int i = 0; i < 11; i++) begin
            drv(1'b1, pkt(32'h5000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("refill_count", 64'(count), 64'd16);
        drv(1'b1, pkt(32'h4ABC), 1'b1, 1'b0);
        #1 chk("full_pop_ready", 64'(push_ready), 64'd0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("after_pop_ready", 64'(push_ready), 64'd1);
        chk("after_pop_count", 64'(count), 64'd15);

        // Flush with concurrent push and pop.
        drv(1'b0, 64'd0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            drv(1'b1, pkt(32'h6000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("pre_flush_count", 64'(count), 64'd7);
        drv(1'b1, pkt(32'h6F00), 1'b1, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(instr_valid), 64'd0);
        chk("flush_ready", 64'(push_ready), 64'd1);
        drv(1'b1, pkt(32'h7000), 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("post_flush_pc", 64'(instr_data[63:32]), 64'h7000);
        chk("post_flush_count", 64'(count), 64'd1);
        drv(1'b0, 64'd0, 1'b1, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1;

        // Empty-queue push: bypass behaviour depends on the build.
`ifdef IQ_BYPASS_EN
        drv(1'b1, {32'hDEADBEEF, 32'h0000_0001}, 1'b1, 1'b0);
        #1 chk("byp_valid", 64'(instr_valid), 64'd1);
        chk("byp_data", instr_data, {32'hDEADBEEF, 32'h0000_0001});
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("byp_count", 64'(count), 64'd0);
`else
        drv(1'b1, {32'hDEADBEEF, 32'h0000_0001}, 1'b0, 1'b0);
        #1 chk("nobyp_valid", 64'(instr_valid), 64'd0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("nobyp_count", 64'(count), 64'd1);
        drv(1'b0, 64'd0, 1'b1, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
`endif
        drv(1'b1, {32'hDEADBEEF, 32'h0000_0002}, 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        #1 chk("push_nopop_count", 64'(count), 64'd1);
        chk("push_nopop_data", instr_data, {32'hDEADBEEF, 32'h0000_0002});
        drv(1'b0, 64'd0, 1'b1, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
